alarm_bank: RTL and testbench
=============================

Name: alarm_bank

Overview:
Parametrised multi-channel alarm unit for the clock/calendar design. It replaces the single fixed hh:mm comparator and stores NUM_ALARMS independently programmable BCD alarm times. Each channel has its own ring/snooze/timeout state machine. It takes the BCD time from the timekeeping counters and drives the alarm LED bar and ring flags. All logic runs on the system clock; a 1 Hz enable pulse paces the timing.

Parameters:
NUM_ALARMS, 4, number of alarm channels (1..8)
CH_W, 2, width of the channel index; must satisfy 2**CH_W >= NUM_ALARMS
SNOOZE_S, 300, snooze length in seconds (1..4095)
RING_TIMEOUT_S, 60, seconds a channel rings before it auto-stops (1..255)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
tick_1hz  in  1  one-clk-wide pulse, once per second
cur_hr  in  8  current hour, BCD {tens,ones}
cur_min  in  8  current minute, BCD
cur_sec  in  8  current second, BCD
wr_en  in  1  one-clk-wide write strobe
wr_ch  in  CH_W  channel to write
wr_hr  in  8  alarm hour, BCD
wr_min  in  8  alarm minute, BCD
wr_arm  in  1  channel enable value to write
dismiss  in  1  one-clk-wide pulse (debounced button)
snooze  in  1  one-clk-wide pulse (debounced button)
ring  out  NUM_ALARMS  per-channel ringing flag
any_ring  out  1  OR of ring
ring_ch  out  CH_W  lowest-index ringing channel; 0 when none is ringing
wr_err  out  1  one-clk pulse when a write is rejected
led_alarm  out  8  blinking LED bar

Behaviour:
- Reset is synchronous, active-low, sampled on posedge clk. While reset==0:
  - all channels go to IDLE with alarm 00:00 and arm=0;
  - all counters clear;
  - ring=0, any_ring=0, ring_ch=0, wr_err=0, led_alarm=8'h00.
- Write path:
  - A write on wr_en is accepted only if: wr_ch < NUM_ALARMS, every BCD nibble <= 9, hour <= 23, minute <= 59.
  - An accepted write stores hr/min/arm on the next edge and forces that channel to IDLE, which also aborts any ring or snooze in progress.
  - A rejected write leaves state unchanged and pulses wr_err high for exactly 1 clk, registered.
- Per-channel FSM states: IDLE, RINGING, SNOOZED.
  - IDLE -> RINGING when all hold: tick_1hz, arm=1, cur_sec==8'h00, cur_hr==alarm_hr, cur_min==alarm_min. The timeout counter loads 0.
  - RINGING: on each tick_1hz the timeout counter increments. When it reaches RING_TIMEOUT_S the channel returns to IDLE.
  - RINGING -> SNOOZED on snooze. The snooze counter loads SNOOZE_S (12-bit).
  - SNOOZED: on each tick_1hz the snooze counter decrements. When it reaches 0 the channel goes to RINGING and the timeout counter reloads 0. A new time match while SNOOZED is ignored.
  - dismiss sends every RINGING and SNOOZED channel to IDLE.
- Priority within one clk, highest first: reset > accepted write to that channel > dismiss > snooze > tick-driven transitions.
- Outputs:
  - ring[k] is 1 exactly while channel k is in RINGING. It is registered, so it rises 1 clk after the triggering tick edge.
  - ring_ch is a combinational priority encode of ring.
  - led_alarm is 8'h00 while any_ring=0. The edge where any_ring goes 0->1 sets led_alarm=8'hFF. Each later tick_1hz while ringing inverts it.
- Multiple channels may ring at once; snooze and dismiss act on all of them.

Optional Feature:
ALARM_MISSED_EN
- Defined:
  - adds output missed (NUM_ALARMS wide) and input missed_clr (1, one-clk pulse);
  - missed[k] sets when channel k leaves RINGING by timeout;
  - missed[k] clears on reset, on missed_clr, or on an accepted write to channel k.
- Not defined: no missed port, no missed_clr port, no missed storage.

Test Plan:
- Write ch1 = 07:30, arm=1; drive 07:30:00 with tick_1hz -> ring=4'b0010 one clk later, ring_ch=1, led_alarm=8'hFF; next tick -> led_alarm=8'h00.
- Ring ch1, then pulse snooze -> ring=0; after 300 ticks -> ring[1]=1 again; pulse dismiss -> ring=0 and the channel stays IDLE past 300 more ticks.
- Ring with no response -> ring[1] drops on the 60th tick. With ALARM_MISSED_EN defined, missed[1]=1 until missed_clr.
- Arm ch0 and ch2 both at 12:00; drive 12:00:00 -> ring=4'b0101, ring_ch=0; dismiss and snooze in the same clk -> both channels IDLE.
- Write hr=8'h24, or min=8'h5A, or wr_ch=5 with NUM_ALARMS=4 -> wr_err pulses for 1 clk and stored values are unchanged. Write ch1 while it rings -> ring[1]=0 next clk.
- Assert reset=0 mid-snooze -> all outputs 0 on the next edge; after reset, 00:00:00 with tick does not ring because arm=0.

Source files
------------

// File: rtl/alarm_bank.sv
`default_nettype none
// ============================================================================
// Module   : alarm_bank
// Purpose  : Multi-channel BCD alarm unit. Holds NUM_ALARMS programmable
//            hh:mm alarm times, each with its own IDLE/RINGING/SNOOZED state
//            machine, ring timeout and snooze countdown. Drives per-channel
//            ring flags, a priority-encoded ringing channel and a blinking
//            LED bar. All timing is paced by a one-clock 1 Hz enable pulse.
//
// Ports    : clk        - system clock
//            reset      - synchronous, active-low reset
//            tick_1hz   - one-clk pulse, once per second
//            cur_hr/min/sec - current time, BCD {tens,ones}
//            wr_en      - one-clk write strobe
//            wr_ch      - channel index to write
//            wr_hr/wr_min - alarm time to store, BCD
//            wr_arm     - channel enable to store
//            dismiss    - stops every ringing or snoozed channel
//            snooze     - snoozes every ringing channel
//            ring       - per-channel ringing flag (registered)
//            any_ring   - OR of ring
//            ring_ch    - lowest ringing channel index, 0 when none
//            wr_err     - one-clk pulse when a write is rejected
//            led_alarm  - blinking LED bar
//            missed     - (ALARM_MISSED_EN only) channel timed out unanswered
//            missed_clr - (ALARM_MISSED_EN only) clears all missed flags
//
// Options  : define ALARM_MISSED_EN to add the missed/missed_clr ports and
//            the per-channel missed flags.
//
// Revision : 1.0 - initial release
// ============================================================================
module alarm_bank #(
    parameter int NUM_ALARMS     = 4,
    parameter int CH_W           = 2,
    parameter int SNOOZE_S       = 300,
    parameter int RING_TIMEOUT_S = 60
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick_1hz,
    input  logic [7:0]            cur_hr,
    input  logic [7:0]            cur_min,
    input  logic [7:0]            cur_sec,
    input  logic                  wr_en,
    input  logic [CH_W-1:0]       wr_ch,
    input  logic [7:0]            wr_hr,
    input  logic [7:0]            wr_min,
    input  logic                  wr_arm,
    input  logic                  dismiss,
    input  logic                  snooze,
    output logic [NUM_ALARMS-1:0] ring,
    output logic                  any_ring,
    output logic [CH_W-1:0]       ring_ch,
    output logic                  wr_err,
    output logic [7:0]            led_alarm
`ifdef ALARM_MISSED_EN
    ,
    input  logic                  missed_clr,
    output logic [NUM_ALARMS-1:0] missed
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZED = 2'd2
    } state_t;

    // One 12-bit counter per channel serves both the ring timeout (counts
    // up) and the snooze countdown; a channel only ever needs one of them.
    localparam logic [11:0] C_SNOOZE_LOAD = 12'(SNOOZE_S);
    localparam logic [11:0] C_TMO_LAST    = 12'(RING_TIMEOUT_S - 1);

    // ------------------------------------------------------------------
    // Write validation
    // ------------------------------------------------------------------
    logic                  w_bcd_ok;
    logic                  w_range_ok;
    logic                  w_ch_ok;
    logic                  w_wr_accept;
    logic [NUM_ALARMS-1:0] w_wr_hit;
    logic [NUM_ALARMS-1:0] ring_d;
    logic [NUM_ALARMS-1:0] ring_q;
    logic                  wr_err_q;
    logic [7:0]            led_q;
    logic [CH_W-1:0]       w_ring_ch;
    logic                  w_any_ring_d;

`ifdef ALARM_MISSED_EN
    logic [NUM_ALARMS-1:0] w_timeout;
    logic [NUM_ALARMS-1:0] missed_q;
`endif

    assign w_bcd_ok   = (wr_hr[7:4]  <= 4'd9) && (wr_hr[3:0]  <= 4'd9) &&
                        (wr_min[7:4] <= 4'd9) && (wr_min[3:0] <= 4'd9);
    // With every nibble valid, a plain byte compare against the BCD limit
    // is the same as a decimal range check.
    assign w_range_ok = (wr_hr <= 8'h23) && (wr_min <= 8'h59);
    assign w_ch_ok    = (32'(wr_ch) < 32'(NUM_ALARMS));

    assign w_wr_accept = wr_en && w_bcd_ok && w_range_ok && w_ch_ok;

    // ------------------------------------------------------------------
    // Per-channel state machines
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_ch
        state_t      state_q;
        state_t      state_d;
        logic [11:0] cnt_q;
        logic [11:0] cnt_d;
        logic [7:0]  hr_q;
        logic [7:0]  hr_d;
        logic [7:0]  min_q;
        logic [7:0]  min_d;
        logic        arm_q;
        logic        arm_d;
        logic        w_match;

        assign w_wr_hit[gi] = w_wr_accept && (wr_ch == CH_W'(gi));
        assign w_match      = arm_q && (cur_sec == 8'h00) &&
                              (cur_hr == hr_q) && (cur_min == min_q);

        // Priority: write to this channel > dismiss > snooze > tick.
        // Dismiss and snooze only pre-empt the tick path in the states
        // they actually act on.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            hr_d    = hr_q;
            min_d   = min_q;
            arm_d   = arm_q;
            if (w_wr_hit[gi]) begin
                hr_d    = wr_hr;
                min_d   = wr_min;
                arm_d   = wr_arm;
                state_d = ST_IDLE;
                cnt_d   = 12'd0;
            end else if (dismiss && (state_q != ST_IDLE)) begin
                state_d = ST_IDLE;
                cnt_d   = 12'd0;
            end else if (snooze && (state_q == ST_RINGING)) begin
                state_d = ST_SNOOZED;
                cnt_d   = C_SNOOZE_LOAD;
            end else if (tick_1hz) begin
                case (state_q)
                    ST_IDLE: begin
                        if (w_match) begin
                            state_d = ST_RINGING;
                            cnt_d   = 12'd0;
                        end
                    end
                    ST_RINGING: begin
                        // Leaves on the tick that would make the count
                        // equal RING_TIMEOUT_S.
                        if (cnt_q == C_TMO_LAST) begin
                            state_d = ST_IDLE;
                            cnt_d   = 12'd0;
                        end else begin
                            cnt_d = cnt_q + 12'd1;
                        end
                    end
                    ST_SNOOZED: begin
                        // Re-rings on the tick that would take the count
                        // to zero; time matches are ignored here.
                        if (cnt_q == 12'd1) begin
                            state_d = ST_RINGING;
                            cnt_d   = 12'd0;
                        end else begin
                            cnt_d = cnt_q - 12'd1;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        cnt_d   = 12'd0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                state_q <= ST_IDLE;
                cnt_q   <= 12'd0;
                hr_q    <= 8'h00;
                min_q   <= 8'h00;
                arm_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                hr_q    <= hr_d;
                min_q   <= min_d;
                arm_q   <= arm_d;
            end
        end

        assign ring_d[gi] = (state_d == ST_RINGING);

`ifdef ALARM_MISSED_EN
        // Only the timeout path moves RINGING to IDLE without a write to
        // this channel or a dismiss.
        assign w_timeout[gi] = (state_q == ST_RINGING) &&
                               (state_d == ST_IDLE) &&
                               !w_wr_hit[gi] && !dismiss;
`endif
    end

    // ------------------------------------------------------------------
    // Shared registered outputs
    // ------------------------------------------------------------------
    assign w_any_ring_d = |ring_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ring_q   <= '0;
            wr_err_q <= 1'b0;
            led_q    <= 8'h00;
        end else begin
            ring_q   <= ring_d;
            wr_err_q <= wr_en && !w_wr_accept;
            // Dark when nothing rings; full on at the start of a ringing
            // episode; then toggles once per second.
            if (!w_any_ring_d) begin
                led_q <= 8'h00;
            end else if (!(|ring_q)) begin
                led_q <= 8'hFF;
            end else if (tick_1hz) begin
                led_q <= ~led_q;
            end
        end
    end

`ifdef ALARM_MISSED_EN
    // A timeout in the same clock as missed_clr still leaves the flag set,
    // so a fresh miss is never lost.
    always_ff @(posedge clk) begin
        if (!reset) begin
            missed_q <= '0;
        end else begin
            missed_q <= (missed_q & ~w_wr_hit & ~{NUM_ALARMS{missed_clr}}) |
                        w_timeout;
        end
    end

    assign missed = missed_q;
`endif

    // Lowest-index ringing channel.
    always_comb begin
        w_ring_ch = '0;
        for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
            if (ring_q[k]) begin
                w_ring_ch = CH_W'(k);
            end
        end
    end

    assign ring      = ring_q;
    assign any_ring  = |ring_q;
    assign ring_ch   = w_ring_ch;
    assign wr_err    = wr_err_q;
    assign led_alarm = led_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarm_bank
// Purpose  : Directed self-checking bench for alarm_bank (4 channels, 3-bit
//            channel index so out-of-range channel numbers can be written).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alarm_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1hz;
    logic [7:0] cur_hr;
    logic [7:0] cur_min;
    logic [7:0] cur_sec;
    logic       wr_en;
    logic [2:0] wr_ch;
    logic [7:0] wr_hr;
    logic [7:0] wr_min;
    logic       wr_arm;
    logic       dismiss;
    logic       snooze;
    logic [3:0] ring;
    logic       any_ring;
    logic [2:0] ring_ch;
    logic       wr_err;
    logic [7:0] led_alarm;
`ifdef ALARM_MISSED_EN
    logic       missed_clr;
    logic [3:0] missed;
`endif

    int checks = 0;
    int errors = 0;

    alarm_bank #(
        .NUM_ALARMS    (4),
        .CH_W          (3),
        .SNOOZE_S      (300),
        .RING_TIMEOUT_S(60)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tick_1hz (tick_1hz),
        .cur_hr   (cur_hr),
        .cur_min  (cur_min),
        .cur_sec  (cur_sec),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_hr    (wr_hr),
        .wr_min   (wr_min),
        .wr_arm   (wr_arm),
        .dismiss  (dismiss),
        .snooze   (snooze),
        .ring     (ring),
        .any_ring (any_ring),
        .ring_ch  (ring_ch),
        .wr_err   (wr_err),
        .led_alarm(led_alarm)
`ifdef ALARM_MISSED_EN
        ,
        .missed_clr(missed_clr),
        .missed    (missed)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        cur_hr   = h;
        cur_min  = m;
        cur_sec  = s;
        tick_1hz = 1'b1;
        clk_step();
        tick_1hz = 1'b0;
    endtask

    task automatic idle_tick(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        do_tick(h, m, s);
        clk_step();
    endtask

    task automatic do_write(input logic [2:0] ch, input logic [7:0] h, input logic [7:0] m,
                            input logic arm);
        wr_en  = 1'b1;
        wr_ch  = ch;
        wr_hr  = h;
        wr_min = m;
        wr_arm = arm;
        clk_step();
        wr_en  = 1'b0;
    endtask

    logic saw_ring;

    initial begin
        reset    = 1'b0;
        tick_1hz = 1'b0;
        cur_hr   = 8'h00;
        cur_min  = 8'h00;
        cur_sec  = 8'h00;
        wr_en    = 1'b0;
        wr_ch    = 3'd0;
        wr_hr    = 8'h00;
        wr_min   = 8'h00;
        wr_arm   = 1'b0;
        dismiss  = 1'b0;
        snooze   = 1'b0;
`ifdef ALARM_MISSED_EN
        missed_clr = 1'b0;
`endif

        // Reset state
        repeat (3) clk_step();
        chk("rst_ring", ring, 4'b0000);
        chk("rst_any", any_ring, 1'b0);
        chk("rst_ring_ch", ring_ch, 3'd0);
        chk("rst_wr_err", wr_err, 1'b0);
        chk("rst_led", led_alarm, 8'h00);
        reset = 1'b1;
        clk_step();

        // Basic ring on ch1 at 07:30
        do_write(3'd1, 8'h07, 8'h30, 1'b1);
        chk("wr_ok_err", wr_err, 1'b0);
        idle_tick(8'h07, 8'h29, 8'h59);
        chk("pre_match", ring, 4'b0000);
        do_tick(8'h07, 8'h30, 8'h00);
        chk("ring1", ring, 4'b0010);
        chk("ring1_ch", ring_ch, 3'd1);
        chk("ring1_any", any_ring, 1'b1);
        chk("ring1_led", led_alarm, 8'hFF);
        clk_step();
        idle_tick(8'h07, 8'h30, 8'h01);
        chk("led_blink0", led_alarm, 8'h00);
        idle_tick(8'h07, 8'h30, 8'h02);
        chk("led_blink1", led_alarm, 8'hFF);

        // Snooze, re-ring after 300 ticks, then dismiss
        snooze = 1'b1;
        clk_step();
        snooze = 1'b0;
        chk("snz_ring", ring, 4'b0000);
        chk("snz_led", led_alarm, 8'h00);
        for (int i = 0; i < 299; i++) idle_tick(8'h07, 8'h35, 8'h00);
        chk("snz_299", ring, 4'b0000);
        do_tick(8'h07, 8'h35, 8'h00);
        chk("snz_300", ring, 4'b0010);
        chk("snz_300_led", led_alarm, 8'hFF);
        clk_step();
        dismiss = 1'b1;
        clk_step();
        dismiss = 1'b0;
        chk("dis_ring", ring, 4'b0000);
        saw_ring = 1'b0;
        for (int i = 0; i < 310; i++) begin
            idle_tick(8'h07, 8'h40, 8'h00);
            if (ring != 4'b0000) saw_ring = 1'b1;
        end
        chk("dis_stays_idle", saw_ring, 1'b0);

        // Timeout after 60 ticks
        idle_tick(8'h07, 8'h30, 8'h00);
        chk("tmo_start", ring, 4'b0010);
        for (int i = 0; i < 59; i++) idle_tick(8'h07, 8'h30, 8'h01);
        chk("tmo_59", ring, 4'b0010);
        do_tick(8'h07, 8'h30, 8'h01);
        chk("tmo_60", ring, 4'b0000);
        chk("tmo_led", led_alarm, 8'h00);
`ifdef ALARM_MISSED_EN
        clk_step();
        chk("missed_set", missed, 4'b0010);
        missed_clr = 1'b1;
        clk_step();
        missed_clr = 1'b0;
        chk("missed_clr", missed, 4'b0000);
`endif

        // Two channels at 12:00; dismiss and snooze in the same clock
        do_write(3'd0, 8'h12, 8'h00, 1'b1);
        do_write(3'd2, 8'h12, 8'h00, 1'b1);
        do_tick(8'h12, 8'h00, 8'h00);
        chk("dual_ring", ring, 4'b0101);
        chk("dual_ring_ch", ring_ch, 3'd0);
        dismiss = 1'b1;
        snooze  = 1'b1;
        clk_step();
        dismiss = 1'b0;
        snooze  = 1'b0;
        chk("dual_dis", ring, 4'b0000);
        chk("dual_dis_any", any_ring, 1'b0);
        saw_ring = 1'b0;
        for (int i = 0; i < 301; i++) begin
            idle_tick(8'h12, 8'h00, 8'h01);
            if (ring != 4'b0000) saw_ring = 1'b1;
        end
        chk("dual_not_snoozed", saw_ring, 1'b0);

        // Rejected writes leave ch1 at 07:30 armed
        do_write(3'd1, 8'h24, 8'h30, 1'b0);
        chk("bad_hr_err", wr_err, 1'b1);
        clk_step();
        chk("bad_hr_pulse", wr_err, 1'b0);
        do_write(3'd1, 8'h07, 8'h5A, 1'b0);
        chk("bad_min_err", wr_err, 1'b1);
        clk_step();
        do_write(3'd5, 8'h07, 8'h30, 1'b0);
        chk("bad_ch_err", wr_err, 1'b1);
        clk_step();
        do_write(3'd1, 8'h1A, 8'h30, 1'b0);
        chk("bad_nib_err", wr_err, 1'b1);
        clk_step();
        do_tick(8'h07, 8'h30, 8'h00);
        chk("unchanged_ring", ring, 4'b0010);

        // Write to a ringing channel aborts the ring
        clk_step();
        do_write(3'd1, 8'h07, 8'h30, 1'b1);
        chk("wr_abort", ring, 4'b0000);
        chk("wr_abort_err", wr_err, 1'b0);

        // Reset during snooze
        idle_tick(8'h07, 8'h30, 8'h00);
        chk("pre_rst_ring", ring, 4'b0010);
        snooze = 1'b1;
        clk_step();
        snooze = 1'b0;
        for (int i = 0; i < 10; i++) idle_tick(8'h07, 8'h31, 8'h00);
        reset = 1'b0;
        clk_step();
        chk("mid_rst_ring", ring, 4'b0000);
        chk("mid_rst_led", led_alarm, 8'h00);
        chk("mid_rst_ring_ch", ring_ch, 3'd0);
        reset = 1'b1;
        clk_step();
        saw_ring = 1'b0;
        idle_tick(8'h00, 8'h00, 8'h00);
        if (ring != 4'b0000) saw_ring = 1'b1;
        for (int i = 0; i < 301; i++) begin
            idle_tick(8'h00, 8'h00, 8'h01);
            if (ring != 4'b0000) saw_ring = 1'b1;
        end
        chk("post_rst_no_ring", saw_ring, 1'b0);
        chk("post_rst_led", led_alarm, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
